// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Shares one synchronous video RAM port between the display fetch and two
//   writer ports. The display always wins while the beam is in the active
//   area. During blanking the two writers are served round-robin, with at
//   most MAX_BURST grants in a row before the other writer gets a turn.
//   Also produces a start-of-vertical-blanking tick and a frame counter.
//
// Ports
//   clk, rst               pixel clock, synchronous active-high reset
//   hblnk, vblnk           blanking flags from the timing generator
//   disp_addr              display fetch address
//   disp_rdata, disp_valid display read data / "holds a display fetch"
//   reqN, weN, addrN,      writer port N request, access type (1 = write),
//   wdataN                 address and write data (N = 0, 1)
//   gntN, rvalidN          access accepted this cycle / read data valid
//   mem_addr, mem_we,      RAM address, write enable, write data
//   mem_wdata, mem_rdata   and read data (one cycle after the address)
//   frame_tick, frame_cnt  vblnk rising-edge pulse / frames since reset
module vram_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 12,
  parameter int MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hblnk,
  input  logic          vblnk,
  input  logic [AW-1:0] disp_addr,
  output logic [DW-1:0] disp_rdata,
  output logic          disp_valid,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          frame_tick,
  output logic [15:0]   frame_cnt
);

  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, DISP, W0, W1} state_t;

  state_t        state;
  logic          rr;
  logic [BW-1:0] burst_cnt;
  logic          vblnk_q;
  logic          disp_active;
  logic          burst_full;

  assign disp_active = !hblnk && !vblnk;
  assign burst_full  = (burst_cnt == BW'(MAX_BURST));

  // Once MAX_BURST grants have been given in a writer state, the next cycle
  // is spent re-arbitrating rather than granting, which yields the single
  // arbitration bubble between bursts.
  assign gnt0 = !rst && !disp_active && (state == W0) && req0 && !burst_full;
  assign gnt1 = !rst && !disp_active && (state == W1) && req1 && !burst_full;

  assign disp_rdata = mem_rdata;

  always_comb begin
    mem_addr  = disp_addr;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_addr  = addr0;
      mem_we    = we0;
      mem_wdata = wdata0;
    end else if (gnt1) begin
      mem_addr  = addr1;
      mem_we    = we1;
      mem_wdata = wdata1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr         <= 1'b0;
      burst_cnt  <= '0;
      disp_valid <= 1'b0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      vblnk_q    <= 1'b0;
      frame_tick <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      disp_valid <= disp_active || (state == DISP);
      rvalid0    <= gnt0 && !we0;
      rvalid1    <= gnt1 && !we1;

      vblnk_q    <= vblnk;
      frame_tick <= vblnk && !vblnk_q;
      if (vblnk && !vblnk_q)
        frame_cnt <= frame_cnt + 16'd1;

      if (disp_active) begin
        // Preemption keeps rr, so the interrupted writer is picked first
        // when blanking resumes.
        state     <= DISP;
        burst_cnt <= '0;
      end else begin
        case (state)
          IDLE, DISP: begin
            burst_cnt <= '0;
            if (rr ? req1 : req0) begin
              state <= rr ? W1 : W0;
            end else if (rr ? req0 : req1) begin
              state <= rr ? W0 : W1;
              rr    <= ~rr;
            end else begin
              state <= IDLE;
            end
          end
          W0: begin
            if (!req0) begin
              rr        <= 1'b1;
              state     <= req1 ? W1 : IDLE;
              burst_cnt <= '0;
            end else if (burst_full) begin
              if (req1) begin
                state <= W1;
                rr    <= 1'b1;
              end
              burst_cnt <= '0;
            end else begin
              burst_cnt <= burst_cnt + BW'(1);
            end
          end
          W1: begin
            if (!req1) begin
              rr        <= 1'b0;
              state     <= req0 ? W0 : IDLE;
              burst_cnt <= '0;
            end else if (burst_full) begin
              if (req0) begin
                state <= W0;
                rr    <= 1'b0;
              end
              burst_cnt <= '0;
            end else begin
              burst_cnt <= burst_cnt + BW'(1);
            end
          end
          default: begin
            state     <= IDLE;
            burst_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter
//   Self-checking bench for vram_arbiter. Directed scenario tasks plus a
//   randomized run checked against a cycle-level behavioural model of the
//   arbitration rules and a shadow memory. A small RAM model drives mem_rdata.
module tb_vram_arbiter;
  localparam int AW = 16;
  localparam int DW = 12;
  localparam int MB = 16;
  localparam int OWN_NONE = -1;
  localparam int OWN_DISP = 2;

  logic          clk = 1'b0;
  logic          rst, hblnk, vblnk;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_rdata;
  logic          disp_valid;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          frame_tick;
  logic [15:0]   frame_cnt;

  always #5 clk = ~clk;

  vram_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .hblnk(hblnk), .vblnk(vblnk),
    .disp_addr(disp_addr), .disp_rdata(disp_rdata), .disp_valid(disp_valid),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .frame_tick(frame_tick), .frame_cnt(frame_cnt)
  );

  // Synchronous RAM seen by the DUT
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the RAM, whose turn it is, grants in a row
  int            m_owner = OWN_NONE;
  int            m_rr = 0;
  int            m_streak = 0;
  bit            m_dvalid, m_rv0, m_rv1, m_vq, m_ftick, m_rdchk;
  logic [15:0]   m_fcnt;
  logic [DW-1:0] m_rdexp;
  logic [DW-1:0] mmem [int];
  bit            e_gnt0, e_gnt1, e_we, e_da;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;

  function automatic void model_eval();
    e_da    = !hblnk && !vblnk;
    e_gnt0  = !rst && !e_da && m_owner == 0 && req0 && m_streak < MB;
    e_gnt1  = !rst && !e_da && m_owner == 1 && req1 && m_streak < MB;
    e_we    = e_gnt0 ? we0 : (e_gnt1 ? we1 : 1'b0);
    e_addr  = e_gnt0 ? addr0 : (e_gnt1 ? addr1 : disp_addr);
    e_wdata = e_gnt0 ? wdata0 : wdata1;
  endfunction

  function automatic void model_commit();
    bit rq [2];
    int k, o, pick;
    rq[0] = req0;
    rq[1] = req1;
    if (rst) begin
      m_owner = OWN_NONE; m_rr = 0; m_streak = 0;
      m_dvalid = 0; m_rv0 = 0; m_rv1 = 0; m_vq = 0; m_ftick = 0; m_fcnt = '0;
      return;
    end
    m_dvalid = e_da || m_owner == OWN_DISP;
    m_rv0 = e_gnt0 && !we0;
    m_rv1 = e_gnt1 && !we1;
    if (e_gnt0 || e_gnt1) begin
      if (e_we) mmem[int'(e_addr)] = e_wdata;
      else begin
        m_rdchk = mmem.exists(int'(e_addr));
        if (m_rdchk) m_rdexp = mmem[int'(e_addr)];
      end
    end
    m_ftick = vblnk && !m_vq;
    if (m_ftick) m_fcnt = m_fcnt + 16'd1;
    m_vq = vblnk;
    if (e_da) begin
      m_owner = OWN_DISP; m_streak = 0;
    end else if (m_owner == OWN_NONE || m_owner == OWN_DISP) begin
      pick = rq[m_rr] ? m_rr : (rq[1-m_rr] ? 1 - m_rr : OWN_NONE);
      m_owner = pick;
      if (pick != OWN_NONE) m_rr = pick;
      m_streak = 0;
    end else begin
      k = m_owner; o = 1 - k;
      if (!rq[k]) begin
        m_rr = o; m_owner = rq[o] ? o : OWN_NONE; m_streak = 0;
      end else if (m_streak == MB) begin
        if (rq[o]) begin m_owner = o; m_rr = o; end
        m_streak = 0;
      end else begin
        m_streak++;
      end
    end
  endfunction

  task automatic eval_cycle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic commit_cycle();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    eval_cycle(); commit_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; hblnk = 1'b1; vblnk = 1'b0; disp_addr = '0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0003; wdata0 = 12'h111;
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0004; wdata1 = 12'h222;
    for (int i = 0; i < 3; i++) begin
      eval_cycle();
      checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL reset_gnt0: got %b want 0", gnt0); end
      checks++; if (gnt1 !== 1'b0) begin errors++; $display("FAIL reset_gnt1: got %b want 0", gnt1); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
      if (i > 0) begin
        checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL reset_disp_valid: got %b want 0", disp_valid); end
        checks++; if ({rvalid0, rvalid1} !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b want 00", {rvalid0, rvalid1}); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_frame_tick: got %b want 0", frame_tick); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
      end
      commit_cycle();
    end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    eval_cycle(); commit_cycle();
  endtask

  task automatic test_display();
    hblnk = 1'b0; vblnk = 1'b0; disp_addr = 16'h1234; req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      eval_cycle();
      checks++; if (mem_addr !== 16'h1234) begin errors++; $display("FAIL disp_addr: got %h want 1234", mem_addr); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL disp_mem_we: got %b want 0", mem_we); end
      checks++; if ({gnt0, gnt1} !== 2'b00) begin errors++; $display("FAIL disp_gnt: got %b want 00", {gnt0, gnt1}); end
      checks++; if (disp_valid !== (i > 0)) begin errors++; $display("FAIL disp_valid cyc %0d: got %b want %b", i, disp_valid, i > 0); end
      commit_cycle();
    end
  endtask

  task automatic test_write_single();
    hblnk = 1'b1; req0 = 1'b0; req1 = 1'b0;
    eval_cycle(); commit_cycle();
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0010; wdata0 = 12'hABC;
    for (int i = 0; i < 3; i++) begin
      eval_cycle();
      checks++; if (gnt0 !== (i >= 1)) begin errors++; $display("FAIL wr_gnt0 cyc %0d: got %b want %b", i, gnt0, i >= 1); end
      checks++; if (mem_we !== (i >= 1)) begin errors++; $display("FAIL wr_mem_we cyc %0d: got %b want %b", i, mem_we, i >= 1); end
      if (i >= 1) begin
        checks++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL wr_mem_addr: got %h want 0010", mem_addr); end
        checks++; if (mem_wdata !== 12'hABC) begin errors++; $display("FAIL wr_mem_wdata: got %h want abc", mem_wdata); end
      end
      commit_cycle();
    end
    req0 = 1'b0;
    eval_cycle();
    checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL wr_after_drop: got %b want 0", gnt0); end
    commit_cycle();
  endtask

  task automatic test_burst_rotation();
    int pos, w;
    bit x0, x1;
    hblnk = 1'b1; vblnk = 1'b0; req0 = 1'b0; req1 = 1'b0;
    do_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0020; wdata0 = 12'h0A0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0021; wdata1 = 12'h0B1;
    for (int c = 0; c < 60; c++) begin
      // cycle 0 arbitrates; then runs of MB grants separated by one bubble
      x0 = 1'b0; x1 = 1'b0;
      if (c > 0) begin
        pos = (c - 1) % (MB + 1);
        w = ((c - 1) / (MB + 1)) % 2;
        if (pos != MB) begin x0 = (w == 0); x1 = (w == 1); end
      end
      eval_cycle();
      checks++; if ({gnt0, gnt1} !== {x0, x1}) begin errors++; $display("FAIL burst_gnt cyc %0d: got %b want %b", c, {gnt0, gnt1}, {x0, x1}); end
      commit_cycle();
    end
  endtask

  task automatic test_preempt();
    bit [9:0] g1_exp;
    hblnk = 1'b1; vblnk = 1'b0; req0 = 1'b0; req1 = 1'b0; disp_addr = 16'h0777;
    do_reset();
    g1_exp = 10'b1000011110; // bit c = expected gnt1 in cycle c
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0040; wdata1 = 12'h404;
    for (int c = 0; c < 10; c++) begin
      if (c == 4) begin req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0041; wdata0 = 12'h414; end
      hblnk = (c >= 5 && c <= 7) ? 1'b0 : 1'b1;
      eval_cycle();
      checks++; if (gnt1 !== g1_exp[c]) begin errors++; $display("FAIL preempt_gnt1 cyc %0d: got %b want %b", c, gnt1, g1_exp[c]); end
      checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL preempt_gnt0 cyc %0d: got %b want 0", c, gnt0); end
      if (c >= 5 && c <= 7) begin
        checks++; if (mem_addr !== 16'h0777) begin errors++; $display("FAIL preempt_addr: got %h want 0777", mem_addr); end
      end
      commit_cycle();
    end
  endtask

  task automatic test_read();
    bit seen;
    logic [DW-1:0] v;
    v = DW'($urandom);
    hblnk = 1'b1; vblnk = 1'b0; req0 = 1'b0; req1 = 1'b0;
    eval_cycle(); commit_cycle();
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0200; wdata0 = v;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      eval_cycle(); seen = gnt0; commit_cycle();
    end
    checks++; if (!seen) begin errors++; $display("FAIL read_setup_write: got no gnt0 want gnt0 within 8 cycles"); end
    req0 = 1'b0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0200;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      eval_cycle(); seen = gnt1; commit_cycle();
    end
    checks++; if (!seen) begin errors++; $display("FAIL read_gnt1: got no gnt1 want gnt1 within 8 cycles"); end
    req1 = 1'b0;
    eval_cycle();
    checks++; if (rvalid1 !== 1'b1) begin errors++; $display("FAIL read_rvalid1: got %b want 1", rvalid1); end
    checks++; if (rvalid0 !== 1'b0) begin errors++; $display("FAIL read_rvalid0: got %b want 0", rvalid0); end
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL read_disp_valid: got %b want 0", disp_valid); end
    checks++; if (disp_rdata !== v) begin errors++; $display("FAIL read_data: got %h want %h", disp_rdata, v); end
    commit_cycle();
  endtask

  task automatic test_frames();
    int pulses;
    hblnk = 1'b1; vblnk = 1'b0; req0 = 1'b0; req1 = 1'b0;
    do_reset();
    pulses = 0;
    for (int c = 0; c < 14; c++) begin
      vblnk = (c < 12) && ((c % 4) >= 2);
      eval_cycle();
      checks++; if (frame_tick !== m_ftick) begin errors++; $display("FAIL frame_tick cyc %0d: got %b want %b", c, frame_tick, m_ftick); end
      if (frame_tick === 1'b1) pulses++;
      commit_cycle();
    end
    checks++; if (pulses != 3) begin errors++; $display("FAIL frame_pulses: got %0d want 3", pulses); end
    checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL frame_cnt: got %0d want 3", frame_cnt); end
    // Reset arriving on the cycle a write would be granted
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0055; wdata0 = 12'h777;
    eval_cycle(); commit_cycle();
    rst = 1'b1;
    eval_cycle();
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_grant_mem_we: got %b want 0", mem_we); end
    checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL rst_grant_gnt0: got %b want 0", gnt0); end
    commit_cycle();
    rst = 1'b0;
    eval_cycle();
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_frame_cnt: got %0d want 0", frame_cnt); end
    checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL rst_retry_arb: got %b want 0", gnt0); end
    commit_cycle();
    eval_cycle();
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL rst_retry_gnt0: got %b want 1", gnt0); end
    commit_cycle();
    req0 = 1'b0;
  endtask

  task automatic test_random();
    bit g0, g1;
    g0 = 1'b0; g1 = 1'b0;
    hblnk = 1'b1; vblnk = 1'b0; req0 = 1'b0; req1 = 1'b0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      // a granted access is consumed: drop the request or start a new one
      if (g0) begin
        if ($urandom_range(0, 1) == 0) req0 = 1'b0;
        else begin we0 = 1'($urandom_range(0, 1)); addr0 = AW'($urandom_range(0, 15)); wdata0 = DW'($urandom); end
      end
      if (g1) begin
        if ($urandom_range(0, 1) == 0) req1 = 1'b0;
        else begin we1 = 1'($urandom_range(0, 1)); addr1 = AW'($urandom_range(0, 15)); wdata1 = DW'($urandom); end
      end
      if (!req0 && $urandom_range(0, 2) == 0) begin
        req0 = 1'b1; we0 = 1'($urandom_range(0, 1)); addr0 = AW'($urandom_range(0, 15)); wdata0 = DW'($urandom);
      end
      if (!req1 && $urandom_range(0, 2) == 0) begin
        req1 = 1'b1; we1 = 1'($urandom_range(0, 1)); addr1 = AW'($urandom_range(0, 15)); wdata1 = DW'($urandom);
      end
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 7) == 0) hblnk = ~hblnk;
      if ($urandom_range(0, 39) == 0) vblnk = ~vblnk;
      disp_addr = AW'($urandom_range(0, 15));
      eval_cycle();
      checks++; if (gnt0 !== e_gnt0) begin errors++; $display("FAIL rand_gnt0 cyc %0d: got %b want %b", c, gnt0, e_gnt0); end
      checks++; if (gnt1 !== e_gnt1) begin errors++; $display("FAIL rand_gnt1 cyc %0d: got %b want %b", c, gnt1, e_gnt1); end
      checks++; if (mem_we !== e_we) begin errors++; $display("FAIL rand_mem_we cyc %0d: got %b want %b", c, mem_we, e_we); end
      if (e_da || m_owner == OWN_DISP || e_gnt0 || e_gnt1) begin
        checks++; if (mem_addr !== e_addr) begin errors++; $display("FAIL rand_mem_addr cyc %0d: got %h want %h", c, mem_addr, e_addr); end
      end
      if (e_we) begin
        checks++; if (mem_wdata !== e_wdata) begin errors++; $display("FAIL rand_mem_wdata cyc %0d: got %h want %h", c, mem_wdata, e_wdata); end
      end
      checks++; if (disp_valid !== m_dvalid) begin errors++; $display("FAIL rand_disp_valid cyc %0d: got %b want %b", c, disp_valid, m_dvalid); end
      checks++; if ({rvalid0, rvalid1} !== {m_rv0, m_rv1}) begin errors++; $display("FAIL rand_rvalid cyc %0d: got %b want %b", c, {rvalid0, rvalid1}, {m_rv0, m_rv1}); end
      if ((m_rv0 || m_rv1) && m_rdchk) begin
        checks++; if (disp_rdata !== m_rdexp) begin errors++; $display("FAIL rand_rdata cyc %0d: got %h want %h", c, disp_rdata, m_rdexp); end
      end
      checks++; if (frame_tick !== m_ftick) begin errors++; $display("FAIL rand_frame_tick cyc %0d: got %b want %b", c, frame_tick, m_ftick); end
      checks++; if (frame_cnt !== m_fcnt) begin errors++; $display("FAIL rand_frame_cnt cyc %0d: got %0d want %0d", c, frame_cnt, m_fcnt); end
      checks++;
      if ((gnt0 && gnt1) || (e_da && (gnt0 || gnt1))) begin
        errors++; $display("FAIL rand_exclusive cyc %0d: got gnt=%b%b disp=%b want at most one owner", c, gnt0, gnt1, e_da);
      end
      g0 = e_gnt0; g1 = e_gnt1;
      commit_cycle();
    end
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit want normal completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_display();
    test_write_single();
    test_burst_rotation();
    test_preempt();
    test_read();
    test_frames();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
